// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: access-size encodings, size decode and default geometry.
package store_buffer_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  // Byte count of an access from the low two funct3 bits.
  function automatic logic [3:0] size_bytes(input logic [1:0] f3);
    logic [3:0] n;
    case (size_e'(f3))
      SZ_B:    n = 4'd1;
      SZ_H:    n = 4'd2;
      SZ_W:    n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sb_overlap_check.sv
// Combinational test of whether two byte spans [addr, addr+size-1] share any byte.
module sb_overlap_check
  import store_buffer_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] i_addr_a,
  input  logic [1:0]      i_size_a,
  input  logic [XLEN-1:0] i_addr_b,
  input  logic [1:0]      i_size_b,
  output logic            o_overlap
);

  localparam int unsigned AW = XLEN + 1;

  logic [AW-1:0] w_a_lo;
  logic [AW-1:0] w_a_hi;
  logic [AW-1:0] w_b_lo;
  logic [AW-1:0] w_b_hi;

  // One extra bit keeps spans near the top of the address space from wrapping.
  assign w_a_lo = {1'b0, i_addr_a};
  assign w_b_lo = {1'b0, i_addr_b};
  assign w_a_hi = w_a_lo + AW'(size_bytes(i_size_a)) - AW'(1);
  assign w_b_hi = w_b_lo + AW'(size_bytes(i_size_b)) - AW'(1);

  assign o_overlap = (w_a_lo <= w_b_hi) && (w_b_lo <= w_a_hi);

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer in front of a single data-memory port; loads bypass the queue
// unless they overlap a buffered store or the queue is full.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_addr,
  input  logic [63:0]     st_data,
  input  logic [2:0]      st_funct3,
  output logic            st_ready,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [2:0]      ld_funct3,
  output logic            ld_stall,
  output logic [63:0]     ld_data,
  output logic            fence_done,
  output logic [XLEN-1:0] mem_addr,
  output logic [63:0]     mem_write_data,
  output logic [2:0]      mem_funct3,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [63:0]     mem_read_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_valid;
  logic [XLEN-1:0]  r_addr [DEPTH];
  logic [63:0]      r_data [DEPTH];
  logic [1:0]       r_size [DEPTH];

  logic [DEPTH-1:0] w_ovl;
  logic [DEPTH-1:0] w_hit;
  logic             w_full;
  logic             w_empty;
  logic             w_conflict;
  logic             w_ld_issue;
  logic             w_drain;
  logic             w_enq;
  logic             w_unused_f3;

  // Stores carry only their size; the sign bit of funct3 has no meaning for a write.
  assign w_unused_f3 = st_funct3[2];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ovl
    sb_overlap_check #(.XLEN(XLEN)) u_ovl (
      .i_addr_a  (ld_addr),
      .i_size_a  (ld_funct3[1:0]),
      .i_addr_b  (r_addr[gi]),
      .i_size_b  (r_size[gi]),
      .o_overlap (w_ovl[gi])
    );
  end

  assign w_hit      = w_ovl & r_valid;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_conflict = ld_valid && (|w_hit);

  // Reset forces the idle view: loads pass straight through, nothing drains.
  assign w_ld_issue = ld_valid && (reset || (!w_conflict && !w_full));
  assign w_drain    = !reset && !w_ld_issue && !w_empty;
  assign w_enq      = !reset && st_valid && !w_full;

  assign st_ready   = reset || !w_full;
  assign ld_stall   = ld_valid && !w_ld_issue;
  assign ld_data    = mem_read_data;
  assign fence_done = reset || w_empty;

  always_comb begin
    mem_read       = w_ld_issue;
    mem_write      = w_drain;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_funct3     = '0;
    if (w_ld_issue) begin
      mem_addr   = ld_addr;
      mem_funct3 = ld_funct3;
    end else if (w_drain) begin
      mem_addr       = r_addr[r_head];
      mem_write_data = r_data[r_head];
      mem_funct3     = {1'b0, r_size[r_head]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_enq && !w_drain) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_enq && w_drain) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Payload needs no reset; occupancy is tracked by r_valid.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
      r_size[r_tail] <= st_funct3[1:0];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a byte-addressed memory model on the data port.
module tb_store_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_D  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;

  logic            clk = 1'b0;
  logic            reset;
  logic            st_valid;
  logic [XLEN-1:0] st_addr;
  logic [63:0]     st_data;
  logic [2:0]      st_funct3;
  logic            st_ready;
  logic            ld_valid;
  logic [XLEN-1:0] ld_addr;
  logic [2:0]      ld_funct3;
  logic            ld_stall;
  logic [63:0]     ld_data;
  logic            fence_done;
  logic [XLEN-1:0] mem_addr;
  logic [63:0]     mem_write_data;
  logic [2:0]      mem_funct3;
  logic            mem_read;
  logic            mem_write;
  logic [63:0]     mem_read_data;

  logic            mem_clr;
  logic [7:0]      mem [1024];
  logic [63:0]     raw;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .st_valid       (st_valid),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .st_funct3      (st_funct3),
    .st_ready       (st_ready),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_funct3      (ld_funct3),
    .ld_stall       (ld_stall),
    .ld_data        (ld_data),
    .fence_done     (fence_done),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_funct3     (mem_funct3),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  // Little-endian memory: writes on the clock, reads combinational with RISC-V load extension.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      for (int i = 0; i < 8; i++)
        if (i < (1 << mem_funct3[1:0])) mem[10'(mem_addr + 32'(i))] <= mem_write_data[i*8 +: 8];
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) raw[i*8 +: 8] = mem[10'(mem_addr + 32'(i))];
    case (mem_funct3)
      3'b000:  mem_read_data = {{56{raw[7]}}, raw[7:0]};
      3'b001:  mem_read_data = {{48{raw[15]}}, raw[15:0]};
      3'b010:  mem_read_data = {{32{raw[31]}}, raw[31:0]};
      3'b100:  mem_read_data = {56'h0, raw[7:0]};
      3'b101:  mem_read_data = {48'h0, raw[15:0]};
      3'b110:  mem_read_data = {32'h0, raw[31:0]};
      default: mem_read_data = raw;
    endcase
  end

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [63:0] sd,
                       input logic [2:0] sf, input logic lv, input logic [31:0] la,
                       input logic [2:0] lf);
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf;
    ld_valid = lv; ld_addr = la; ld_funct3 = lf;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_clr = 1'b1;
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, 32'h80, F_W);
    n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL rst_st_ready: got %h expected 1", st_ready); end
    n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL rst_ld_stall: got %h expected 0", ld_stall); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mem_write: got %h expected 0", mem_write); end
    n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rst_mem_read: got %h expected 1", mem_read); end
    n_cmp++; if (fence_done !== 1'b1) begin n_err++; $display("FAIL rst_fence: got %h expected 1", fence_done); end
    n_cmp++; if (mem_addr !== 32'h80) begin n_err++; $display("FAIL rst_mem_addr: got %h expected 00000080", mem_addr); end
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b0, 32'h0, F_B);
    n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_idle_read: got %h expected 0", mem_read); end
    @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;
    #1;
    n_cmp++; if ({mem_read, mem_write, fence_done, st_ready} !== 4'b0011) begin
      n_err++; $display("FAIL idle_ctrl: got %b expected 0011", {mem_read, mem_write, fence_done, st_ready}); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_write_data !== 64'h0) begin
      n_err++; $display("FAIL idle_bus: got addr %h data %h expected zeros", mem_addr, mem_write_data); end
  endtask

  task automatic test_single_store;
    drive(1'b1, 32'h100, 64'hDEADBEEF, F_W, 1'b0, 32'h0, F_B);
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL ss_no_bypass: got %h expected 0", mem_write); end
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b0, 32'h0, F_B);
    n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL ss_write: got %h expected 1", mem_write); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL ss_addr: got %h expected 00000100", mem_addr); end
    n_cmp++; if (mem_write_data !== 64'hDEADBEEF) begin n_err++; $display("FAIL ss_data: got %h expected deadbeef", mem_write_data); end
    n_cmp++; if (mem_funct3 !== F_W) begin n_err++; $display("FAIL ss_funct3: got %h expected 2", mem_funct3); end
    n_cmp++; if (fence_done !== 1'b0) begin n_err++; $display("FAIL ss_fence_busy: got %h expected 0", fence_done); end
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, 32'h100, F_W);
    n_cmp++; if (fence_done !== 1'b1) begin n_err++; $display("FAIL ss_fence_done: got %h expected 1", fence_done); end
    n_cmp++; if (ld_data !== 64'hFFFFFFFF_DEADBEEF) begin n_err++; $display("FAIL ss_readback: got %h expected ffffffffdeadbeef", ld_data); end
  endtask

  task automatic test_full_buffer;
    logic [31:0] exp_a;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 64'(8'hA1 + 8'(i)), F_B, 1'b1, 32'h300, F_W);
      n_cmp++; if (ld_stall !== 1'b0 || st_ready !== 1'b1) begin
        n_err++; $display("FAIL fill_%0d: got stall %h ready %h expected 0 1", i, ld_stall, st_ready); end
    end
    drive(1'b1, 32'h14, 64'hA5, F_B, 1'b1, 32'h300, F_W);
    n_cmp++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %h expected 0", st_ready); end
    n_cmp++; if (ld_stall !== 1'b1 || mem_read !== 1'b0) begin
      n_err++; $display("FAIL full_stall: got stall %h read %h expected 1 0", ld_stall, mem_read); end
    n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 32'h10 || mem_write_data !== 64'hA1) begin
      n_err++; $display("FAIL full_drain0: got w %h addr %h data %h expected 1 10 a1", mem_write, mem_addr, mem_write_data); end
    drive(1'b1, 32'h14, 64'hA5, F_B, 1'b1, 32'h300, F_W);
    n_cmp++; if (st_ready !== 1'b1 || ld_stall !== 1'b0 || mem_write !== 1'b0) begin
      n_err++; $display("FAIL retry_accept: got ready %h stall %h w %h expected 1 0 0", st_ready, ld_stall, mem_write); end
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, 32'h300, F_W);
    n_cmp++; if (st_ready !== 1'b0 || ld_stall !== 1'b1 || mem_addr !== 32'h11) begin
      n_err++; $display("FAIL refull: got ready %h stall %h addr %h expected 0 1 11", st_ready, ld_stall, mem_addr); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 64'h0, F_B, 1'b0, 32'h0, F_B);
      exp_a = 32'h12 + 32'(i);
      n_cmp++; if (mem_write !== 1'b1 || mem_addr !== exp_a || mem_write_data !== 64'(8'hA3 + 8'(i))) begin
        n_err++; $display("FAIL order_%0d: got w %h addr %h data %h expected 1 %h %h",
                          i, mem_write, mem_addr, mem_write_data, exp_a, 8'hA3 + 8'(i)); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, 32'h10 + 32'(i), F_BU);
      n_cmp++; if (ld_data !== 64'(8'hA1 + 8'(i)) || fence_done !== 1'b1) begin
        n_err++; $display("FAIL full_mem_%0d: got data %h fence %h expected %h 1", i, ld_data, fence_done, 8'hA1 + 8'(i)); end
    end
  endtask

  task automatic test_conflict_lb;
    drive(1'b1, 32'h200, 64'hDEADBEEF, F_W, 1'b0, 32'h0, F_B);
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, 32'h203, F_B);
    n_cmp++; if (ld_stall !== 1'b1 || mem_read !== 1'b0) begin
      n_err++; $display("FAIL lb_stall: got stall %h read %h expected 1 0", ld_stall, mem_read); end
    n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 32'h200) begin
      n_err++; $display("FAIL lb_drain: got w %h addr %h expected 1 200", mem_write, mem_addr); end
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, 32'h203, F_B);
    n_cmp++; if (ld_stall !== 1'b0 || mem_read !== 1'b1) begin
      n_err++; $display("FAIL lb_release: got stall %h read %h expected 0 1", ld_stall, mem_read); end
    n_cmp++; if (ld_data !== 64'hFFFFFFFF_FFFFFFDE) begin n_err++; $display("FAIL lb_data: got %h expected ffffffffffffffde", ld_data); end
  endtask

  // SD at 0x1FC covers bytes 0x1FC..0x203.
  task automatic test_misaligned;
    logic [31:0] la [5] = '{32'h200, 32'h204, 32'h208, 32'h1FC, 32'h1FB};
    logic [2:0]  lf [5] = '{F_W, F_W, F_W, F_B, F_B};
    logic        ex [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1FC, 64'h01020304_05060708, F_D, 1'b0, 32'h0, F_B);
      drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, la[i], lf[i]);
      n_cmp++; if (ld_stall !== ex[i] || mem_read !== !ex[i]) begin
        n_err++; $display("FAIL span_%h: got stall %h read %h expected %h %h", la[i], ld_stall, mem_read, ex[i], !ex[i]); end
      drive(1'b0, 32'h0, 64'h0, F_B, 1'b0, 32'h0, F_B);
      drive(1'b0, 32'h0, 64'h0, F_B, 1'b0, 32'h0, F_B);
      n_cmp++; if (fence_done !== 1'b1) begin n_err++; $display("FAIL span_empty_%0d: got %h expected 1", i, fence_done); end
    end
  endtask

  task automatic test_reset_mid_drain;
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h40 + 32'(4 * i), 64'(32'h11111111 * (i + 1)), F_W, 1'b1, 32'h300, F_W);
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b0, 32'h0, F_B);
    n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 32'h40) begin
      n_err++; $display("FAIL mid_drain0: got w %h addr %h expected 1 40", mem_write, mem_addr); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (mem_write !== 1'b0 || fence_done !== 1'b1 || st_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_rst: got w %h fence %h ready %h expected 0 1 1", mem_write, fence_done, st_ready); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (mem_write !== 1'b0 || fence_done !== 1'b1) begin
        n_err++; $display("FAIL post_rst_%0d: got w %h fence %h expected 0 1", i, mem_write, fence_done); end
      drive(1'b0, 32'h0, 64'h0, F_B, 1'b0, 32'h0, F_B);
    end
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, 32'h40, F_W);
    n_cmp++; if (ld_data !== 64'h11111111) begin n_err++; $display("FAIL kept_40: got %h expected 11111111", ld_data); end
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, 32'h44, F_W);
    n_cmp++; if (ld_data !== 64'h0) begin n_err++; $display("FAIL lost_44: got %h expected 0", ld_data); end
    drive(1'b0, 32'h0, 64'h0, F_B, 1'b1, 32'h48, F_W);
    n_cmp++; if (ld_data !== 64'h0) begin n_err++; $display("FAIL lost_48: got %h expected 0", ld_data); end
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0;
    test_reset();
    test_single_store();
    test_full_buffer();
    test_conflict_lb();
    test_misaligned();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
